// File: rtl/ccip_gray_pkg.sv
// Shared types and grayscale coefficients for the CCI-P line converter.
// A cache line carries 16 RGBA pixels, red in the low byte of each pixel.
package ccip_gray_pkg;

  localparam int NPIX       = 16;
  localparam int GRAY_R     = 77;
  localparam int GRAY_G     = 150;
  localparam int GRAY_B     = 29;
  localparam int GRAY_SHIFT = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } t_pixel;

  typedef t_pixel [NPIX-1:0] t_line;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } t_prod;

endpackage

// File: rtl/ccip_gray_fifo.sv
// Single-clock FIFO with registered read data.
// The pointers carry one extra bit so that full and empty can be told apart.
module ccip_gray_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;
  logic         w_do_wr;
  logic         w_do_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count   = r_wr_ptr - r_rd_ptr;
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ccip_gray_line_conv.sv
// RGBA-to-grayscale line converter between the CCI-P read responses and the write issuer.
// Two-stage never-stalling pipe feeds a FIFO; read credits guarantee the FIFO cannot overflow.
module ccip_gray_line_conv
  import ccip_gray_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int TAG_W = 16
) (
  input  logic                         pClk,
  input  logic                         pck_cp2af_softReset,
  input  logic                         rd_issue,
  output logic                         rd_can_issue,
  input  logic                         in_valid,
  input  logic [511:0]                 in_data,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         out_almfull,
  output logic                         out_valid,
  output logic [511:0]                 out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FW    = TAG_W + 512;
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  t_line            w_in_line;
  t_prod            r_s1_prod  [NPIX];
  logic [7:0]       r_s1_alpha [NPIX];
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_valid;

  logic [15:0]      w_sum  [NPIX];
  logic [7:0]       w_gray [NPIX];
  t_line            r_s2_line;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_valid;

  logic [FW-1:0]    w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic [$clog2(DEPTH):0] w_fifo_count_unused;
  logic             w_pop;
  logic             w_drop;
  logic             r_out_valid;

  logic [CNT_W-1:0] r_occ;
  logic [CNT_W:0]   w_occ_sum;
  logic [CNT_W-1:0] w_occ_next;
  logic             r_can_issue;
  logic             r_ovf;

  assign w_in_line = in_data;

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      for (int k = 0; k < NPIX; k++) begin
        r_s1_prod[k]  <= '0;
        r_s1_alpha[k] <= '0;
      end
    end else begin
      r_s1_valid <= in_valid;
      r_s1_tag   <= in_tag;
      for (int k = 0; k < NPIX; k++) begin
        r_s1_prod[k].r <= 16'(GRAY_R * w_in_line[k].r);
        r_s1_prod[k].g <= 16'(GRAY_G * w_in_line[k].g);
        r_s1_prod[k].b <= 16'(GRAY_B * w_in_line[k].b);
        r_s1_alpha[k]  <= w_in_line[k].a;
      end
    end
  end

  // Coefficients sum to 256, so the 16-bit sum never wraps and gray tops out at 255.
  always_comb begin
    for (int k = 0; k < NPIX; k++) begin
      w_sum[k]  = r_s1_prod[k].r + r_s1_prod[k].g + r_s1_prod[k].b;
      w_gray[k] = 8'(w_sum[k] >> GRAY_SHIFT);
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_line  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      for (int k = 0; k < NPIX; k++) begin
        r_s2_line[k] <= {r_s1_alpha[k], w_gray[k], w_gray[k], w_gray[k]};
      end
    end
  end

  assign w_pop  = !w_empty && !out_almfull;
  assign w_drop = r_s2_valid && w_full;

  ccip_gray_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (pClk),
    .rst     (pck_cp2af_softReset),
    .wr_en   (r_s2_valid),
    .wr_data ({r_s2_tag, r_s2_line}),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_fifo_count_unused)
  );

  // Responses only move a credit from outstanding to buffered; issue and pop change the total.
  always_comb begin
    w_occ_sum = {1'b0, r_occ} + {{CNT_W{1'b0}}, rd_issue};
    if (w_pop && (w_occ_sum != '0)) w_occ_sum = w_occ_sum - 1'b1;
    if (w_occ_sum > DEPTH_X) w_occ_sum = DEPTH_X;
    w_occ_next = w_occ_sum[CNT_W-1:0];
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_occ       <= '0;
      r_can_issue <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_occ       <= w_occ_next;
      r_can_issue <= (w_occ_next < DEPTH_C);
      r_ovf       <= r_ovf || (rd_issue && !r_can_issue) || w_drop;
      r_out_valid <= w_pop;
    end
  end

  assign rd_can_issue = r_can_issue;
  assign occupancy    = r_occ;
  assign overflow_err = r_ovf;
  assign out_valid    = r_out_valid;
  assign out_data     = w_rd_data[511:0];
  assign out_tag      = w_rd_data[FW-1:512];

endmodule

// File: tb/tb_ccip_gray_line_conv.sv
// Self-checking bench for ccip_gray_line_conv: random lines against a grayscale reference,
// credit exhaustion, backpressure, protocol violation and mid-stream reset.
module tb_ccip_gray_line_conv;

  localparam int DEPTH = 64;
  localparam int TAG_W = 16;

  logic               pClk = 1'b0;
  logic               rst = 1'b0;
  logic               rd_issue = 1'b0;
  logic               rd_can_issue;
  logic               in_valid = 1'b0;
  logic [511:0]       in_data = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_almfull = 1'b0;
  logic               out_valid;
  logic [511:0]       out_data;
  logic [TAG_W-1:0]   out_tag;
  logic [6:0]         occupancy;
  logic               overflow_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [TAG_W+511:0] obs_q[$];
  int                 obs_cyc[$];
  logic [TAG_W+511:0] exp_q[$];

  ccip_gray_line_conv #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (rst),
    .rd_issue            (rd_issue),
    .rd_can_issue        (rd_can_issue),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_tag              (in_tag),
    .out_almfull         (out_almfull),
    .out_valid           (out_valid),
    .out_data            (out_data),
    .out_tag             (out_tag),
    .occupancy           (occupancy),
    .overflow_err        (overflow_err)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  always @(negedge pClk) begin
    if (!rst && out_valid) begin
      obs_q.push_back({out_tag, out_data});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: weighted average with integer division, alpha carried through.
  function automatic logic [511:0] gray_ref(input logic [511:0] d);
    logic [511:0] o;
    int r, g, b, y;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r = int'(d[32*k +: 8]);
      g = int'(d[32*k+8 +: 8]);
      b = int'(d[32*k+16 +: 8]);
      y = (77*r + 150*g + 29*b) / 256;
      o[32*k +: 32] = {d[32*k+24 +: 8], y[7:0], y[7:0], y[7:0]};
    end
    return o;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom();
    return l;
  endfunction

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic issue(input int n);
    rd_issue = 1'b1;
    repeat (n) tick();
    rd_issue = 1'b0;
  endtask

  task automatic respond(input logic [511:0] line, input logic [TAG_W-1:0] tag, input bit expect_it);
    in_valid = 1'b1;
    in_data  = line;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    if (expect_it) exp_q.push_back({tag, gray_ref(line)});
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b;
    b = 0;
    while (obs_q.size() < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  task automatic test_reset();
    rd_issue = 0; in_valid = 0; out_almfull = 0;
    #1 rst = 1'b1;
    repeat (3) tick();
    if (rd_can_issue !== 1'b0) begin n_fail++; $display("FAIL reset_can_issue: got %b want 0", rd_can_issue); end n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end n_tests++;
    if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end n_tests++;
    if (occupancy !== 7'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end n_tests++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end n_tests++;
    rst = 1'b0;
    tick();
    if (rd_can_issue !== 1'b1) begin n_fail++; $display("FAIL release_can_issue: got %b want 1", rd_can_issue); end n_tests++;
  endtask

  task automatic test_single();
    logic [511:0]     line;
    logic [TAG_W-1:0] tag;
    for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h80FFFFFF;
    tag = TAG_W'($urandom());
    obs_q.delete(); obs_cyc.delete();
    issue(1);
    if (occupancy !== 7'd1) begin n_fail++; $display("FAIL single_occ_issue: got %0d want 1", occupancy); end n_tests++;
    in_valid = 1'b1; in_data = line; in_tag = tag;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", out_valid); end n_tests++;
    if (occupancy !== 7'd1) begin n_fail++; $display("FAIL single_occ_pipe: got %0d want 1", occupancy); end n_tests++;
    tick();
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b want 1", out_valid); end n_tests++;
    if (out_data !== line) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, line); end n_tests++;
    if (out_tag !== tag) begin n_fail++; $display("FAIL single_tag: got %h want %h", out_tag, tag); end n_tests++;
    if (occupancy !== 7'd0) begin n_fail++; $display("FAIL single_occ_pop: got %0d want 0", occupancy); end n_tests++;
    tick();
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len: got %b want 0", out_valid); end n_tests++;
  endtask

  task automatic test_primary();
    logic [511:0]       line;
    logic [TAG_W+511:0] got;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: line[32*k +: 32] = 32'h000000FF;
        1: line[32*k +: 32] = 32'h0000FF00;
        2: line[32*k +: 32] = 32'h00FF0000;
        default: line[32*k +: 32] = $urandom();
      endcase
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    issue(1);
    respond(line, 16'h1234, 1'b1);
    wait_obs(1, 20);
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL primary_count: got %0d want 1", obs_q.size()); end
    else begin
      got = obs_q[0];
      if (got[TAG_W+511:512] !== 16'h1234) begin n_fail++; $display("FAIL primary_tag: got %h want 1234", got[TAG_W+511:512]); end n_tests++;
      if (got[31:0] !== 32'h004C4C4C) begin n_fail++; $display("FAIL primary_red: got %h want 004c4c4c", got[31:0]); end n_tests++;
      if (got[63:32] !== 32'h00959595) begin n_fail++; $display("FAIL primary_green: got %h want 00959595", got[63:32]); end n_tests++;
      if (got[95:64] !== 32'h001C1C1C) begin n_fail++; $display("FAIL primary_blue: got %h want 001c1c1c", got[95:64]); end n_tests++;
      if (got !== exp_q[0]) begin n_fail++; $display("FAIL primary_line: got %h want %h", got, exp_q[0]); end
    end
    n_tests++;
  endtask

  task automatic test_random();
    int issued, resp, iter, n, bad;
    n = 40; issued = 0; resp = 0; iter = 0;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    while (resp < n && iter < 2000) begin
      rd_issue    = (issued < n) && rd_can_issue && ($urandom_range(0, 3) != 0);
      in_valid    = (resp < issued) && ($urandom_range(0, 2) != 0);
      out_almfull = ($urandom_range(0, 3) == 0);
      if (in_valid) begin
        in_data = rand_line();
        in_tag  = TAG_W'($urandom());
        exp_q.push_back({in_tag, gray_ref(in_data)});
      end
      tick();
      if (rd_issue) issued++;
      if (in_valid) resp++;
      iter++;
    end
    rd_issue = 0; in_valid = 0; out_almfull = 0;
    wait_obs(n, 200);
    repeat (2) tick();
    if (obs_q.size() != n) begin n_fail++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), n); end n_tests++;
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 3) $display("FAIL random_line%0d: got tag %h want tag %h", i, obs_q[i][TAG_W+511:512], exp_q[i][TAG_W+511:512]);
      end
    end
    if (bad != 0) n_fail++; n_tests++;
    if (occupancy !== 7'd0) begin n_fail++; $display("FAIL random_occ_drain: got %0d want 0", occupancy); end n_tests++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL random_overflow: got %b want 0", overflow_err); end n_tests++;
  endtask

  task automatic test_backpressure();
    int bad;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    issue(63);
    if (rd_can_issue !== 1'b1) begin n_fail++; $display("FAIL credit_63_can: got %b want 1", rd_can_issue); end n_tests++;
    issue(1);
    if (rd_can_issue !== 1'b0) begin n_fail++; $display("FAIL credit_64_can: got %b want 0", rd_can_issue); end n_tests++;
    if (occupancy !== 7'd64) begin n_fail++; $display("FAIL credit_64_occ: got %0d want 64", occupancy); end n_tests++;
    out_almfull = 1'b1;
    for (int i = 0; i < DEPTH; i++) respond(rand_line(), TAG_W'(16'h4000 + i), 1'b1);
    repeat (6) tick();
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_no_strobe: got %0d want 0", obs_q.size()); end n_tests++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b want 0", overflow_err); end n_tests++;
    if (occupancy !== 7'd64) begin n_fail++; $display("FAIL bp_occ: got %0d want 64", occupancy); end n_tests++;
    issue(1);
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL viol_flag: got %b want 1", overflow_err); end n_tests++;
    if (occupancy !== 7'd64) begin n_fail++; $display("FAIL viol_sat: got %0d want 64", occupancy); end n_tests++;
    respond(rand_line(), 16'hDEAD, 1'b0);
    repeat (5) tick();
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL viol_sticky: got %b want 1", overflow_err); end n_tests++;
    out_almfull = 1'b0;
    tick();
    out_almfull = 1'b1;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL onepop_valid: got %b want 1", out_valid); end n_tests++;
    if (rd_can_issue !== 1'b1) begin n_fail++; $display("FAIL onepop_can: got %b want 1", rd_can_issue); end n_tests++;
    if (occupancy !== 7'd63) begin n_fail++; $display("FAIL onepop_occ: got %0d want 63", occupancy); end n_tests++;
    tick();
    out_almfull = 1'b0;
    wait_obs(DEPTH, 120);
    repeat (4) tick();
    if (obs_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_release_count: got %0d want %0d", obs_q.size(), DEPTH); end n_tests++;
    bad = 0;
    for (int i = 2; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_consecutive: got %0d gaps want 0", bad); end n_tests++;
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 3) $display("FAIL bp_line%0d: got tag %h want tag %h", i, obs_q[i][TAG_W+511:512], exp_q[i][TAG_W+511:512]);
      end
    end
    if (bad != 0) n_fail++; n_tests++;
    if (occupancy !== 7'd0) begin n_fail++; $display("FAIL bp_occ_drain: got %0d want 0", occupancy); end n_tests++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL bp_sticky_end: got %b want 1", overflow_err); end n_tests++;
  endtask

  task automatic test_reset_midstream();
    logic [511:0]     line;
    logic [TAG_W-1:0] tag;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    out_almfull = 1'b1;
    issue(10);
    for (int i = 0; i < 10; i++) respond(rand_line(), TAG_W'(i), 1'b0);
    repeat (4) tick();
    if (occupancy !== 7'd10) begin n_fail++; $display("FAIL mid_occ_before: got %0d want 10", occupancy); end n_tests++;
    out_almfull = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end n_tests++;
    if (occupancy !== 7'd0) begin n_fail++; $display("FAIL mid_occ: got %0d want 0", occupancy); end n_tests++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_overflow_clr: got %b want 0", overflow_err); end n_tests++;
    if (rd_can_issue !== 1'b0) begin n_fail++; $display("FAIL mid_can_issue: got %b want 0", rd_can_issue); end n_tests++;
    tick(); tick();
    rst = 1'b0;
    tick();
    obs_q.delete(); obs_cyc.delete();
    repeat (5) tick();
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_flushed: got %0d strobes want 0", obs_q.size()); end n_tests++;
    line = rand_line();
    tag  = TAG_W'($urandom());
    issue(1);
    respond(line, tag, 1'b1);
    wait_obs(1, 20);
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL mid_new_count: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL mid_new_line: got %h want %h", obs_q[0], exp_q[0]); end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_primary();
    test_random();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccip_gray_line_conv.md
Name: ccip_gray_line_conv

Overview:
- Datapath stage directly downstream of the CCI-P async shim, inside the AFU clock domain.
- Consumes 512-bit read-response cache lines of 16 RGBA pixels and converts each pixel to grayscale.
- Buffers converted lines and presents them as write-data strobes to the write-request issuer, honouring c1TxAlmFull.
- Issues read credits upstream so that unbackpressurable read responses can never overflow the buffer.

Parameters:
- DEPTH, 64, line capacity of the internal FIFO and total credit pool; power of two, ≥4.
- TAG_W, 16, width of the per-line tag (CCI-P mdata / line index).

Ports:
- pClk  in  1  AFU clock.
- pck_cp2af_softReset  in  1  asynchronous, active-high reset.
- rd_issue  in  1  one-cycle pulse; upstream requester issued one read request this cycle.
- rd_can_issue  out  1  high when at least one credit is free.
- in_valid  in  1  read response valid (c0 RX, resp type RdLine).
- in_data  in  512  cache line; pixel k occupies bits [32k+31:32k]; bytes within a pixel are R=[7:0], G=[15:8], B=[23:16], A=[31:24].
- in_tag  in  TAG_W  tag returned with the response.
- out_almfull  in  1  c1TxAlmFull from the shim.
- out_valid  out  1  one-cycle strobe carrying one converted line.
- out_data  out  512  converted line.
- out_tag  out  TAG_W  tag of the converted line.
- occupancy  out  $clog2(DEPTH+1)  outstanding reads + lines in pipe + lines in FIFO.
- overflow_err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous and active-high. While in reset and on release: rd_can_issue=0 during reset, out_valid=0, out_data=0, out_tag=0, occupancy=0, overflow_err=0, FIFO empty, pipe empty. rd_can_issue rises in the first cycle after release.
- Conversion per pixel: gray = (77*R + 150*G + 29*B) >> 8.
  - Product sum is 16 bits unsigned; the result is truncated to 8 bits. Coefficients sum to 256, so the maximum result is 255.
  - Output pixel is {A, gray, gray, gray}; alpha passes through unchanged.
- Pipeline:
  - Stage 1 registers the 48 products together with the tag and valid.
  - Stage 2 registers the per-pixel sums shifted right by 8.
  - Stage 2 output writes into the FIFO.
  - The pipe never stalls.
- Output: out_valid asserts in a cycle when the FIFO was non-empty and out_almfull was low at the previous edge. That asserting edge pops the FIFO. out_data and out_tag are registered with the strobe.
- Latency: for in_valid sampled at edge N with the FIFO empty and out_almfull low, out_valid is high in the cycle after edge N+3.
- Throughput: one line per cycle sustained.
- Credit accounting: occupancy(next) = occupancy + rd_issue − out_valid_pop. Responses only move credit from "outstanding" to "pipe/FIFO" and do not change the total.
  - rd_can_issue = (occupancy < DEPTH), registered and computed from the next-state value.
  - All three events in one cycle (issue, response, pop) are legal.
  - An issue and a pop in the same cycle leave occupancy unchanged.
- Boundary conditions:
  - rd_issue while rd_can_issue=0 is a protocol violation. Set overflow_err; occupancy saturates at DEPTH.
  - A line that reaches the FIFO write port while the FIFO is full is dropped and sets overflow_err. This is unreachable when credits are honoured.
  - out_almfull held high: the FIFO fills, occupancy reaches DEPTH, rd_can_issue drops. Nothing is dropped.
  - FIFO pointers wrap modulo DEPTH. Full and empty are distinguished with an extra pointer bit.
  - Reset asserted mid-stream discards pipe and FIFO contents and clears all counters asynchronously.
- overflow_err clears only on reset.

Decomposition:
- Package ccip_gray_pkg:
  - t_pixel (struct of 8-bit a, b, g, r).
  - t_line (array of 16 t_pixel).
  - Coefficient constants GRAY_R=77, GRAY_G=150, GRAY_B=29, GRAY_SHIFT=8.
- Sub-module ccip_gray_fifo:
  - Synchronous single-clock FIFO parameterised by width and DEPTH, same asynchronous active-high reset.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - Registered read data.

Test Plan:
- Single response: rd_issue once, then in_valid with all pixels 0x80FFFFFF -> out_valid 4 cycles later, all pixels 0x80FFFFFF; occupancy returns 1→0.
- Primary colours:
  - Pixel 0x000000FF (red) -> 0x004C4C4C.
  - Pixel 0x0000FF00 (green) -> 0x00959595.
  - Pixel 0x00FF0000 (blue) -> 0x001C1C1C.
  - Tag 0x1234 appears unchanged on out_tag.
- Credit exhaustion with DEPTH=64:
  - Issue 64 reads back-to-back -> rd_can_issue low after the 64th; occupancy=64.
  - One pop -> rd_can_issue high again the following cycle.
- Backpressure: hold out_almfull=1 while 64 responses arrive -> no out_valid, no overflow_err. Release -> 64 strobes on consecutive cycles, tags in arrival order.
- Violation: force rd_issue with rd_can_issue=0, then deliver the 65th response -> overflow_err=1 and stays set; the line is dropped and the FIFO contents are intact.
- Reset mid-stream: assert reset with 10 lines in the FIFO -> out_valid=0, occupancy=0 immediately. After release, the first new response converts correctly.
